cg_phase_sequencer: RTL

//  Parametrised iteration sequencer for the conjugate-gradient solver. Steps one CG iteration through explicit phases:
//  A*p, alpha dot, x/r update, beta dot, p update, check.

---
 rtl/cg_phase_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/cg_phase_sequencer.sv
// Conjugate-gradient iteration sequencer. It steps through the phases of one iteration,
// sweeps the memory read addresses, steers each writeback to its memory and counts iterations.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for start (also the state after an abort)
// S_MATVEC  | sweep A and p to form Ap; writes land in Ap
// S_ALPHA   | sweep vectors for the alpha dot product; no writes
// S_UPDATE  | sweep vectors; writes land in x and r together
// S_BETA    | sweep vectors for the beta dot product; no writes
// S_PUPDATE | sweep vectors; writes land in p
// S_CHECK   | one cycle: count the iteration, then stop or start the next one
// S_DONE    | holds the result until start or abort
module cg_phase_sequencer #(
    parameter int NO_OF_UNITS  = 8,
    parameter int NUM_EQ       = 19,
    parameter int NUM_CLUSTERS = 40,
    parameter int ADDR_W       = 20,
    parameter int MAX_ITER     = 20,
    parameter int ITER_W       = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              stall,
    input  logic              result_valid,
    input  logic              alu_done,
    input  logic              converged,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_rd_addr,
    output logic              vec_rd_en,
    output logic [ADDR_W-1:0] vec_rd_addr,
    output logic [ADDR_W-1:0] vec_wr_addr,
    output logic              wr_en_ap,
    output logic              wr_en_x,
    output logic              wr_en_r,
    output logic              wr_en_p,
    output logic [2:0]        phase,
    output logic [ITER_W-1:0] iter_count,
    output logic              busy,
    output logic              done,
    output logic              conv_flag,
    output logic              wr_overflow
);
    localparam int VEC_WORDS = (NUM_EQ + NO_OF_UNITS - 1) / NO_OF_UNITS;
    localparam int CNT_W     = $clog2(VEC_WORDS + 1);
    localparam logic [ADDR_W-1:0] A_LAST    = ADDR_W'(NUM_CLUSTERS - 1);
    localparam logic [ADDR_W-1:0] V_LAST    = ADDR_W'(VEC_WORDS - 1);
    localparam logic [CNT_W-1:0]  WR_FULL   = CNT_W'(VEC_WORDS);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MATVEC  = 3'd1,
        S_ALPHA   = 3'd2,
        S_UPDATE  = 3'd3,
        S_BETA    = 3'd4,
        S_PUPDATE = 3'd5,
        S_CHECK   = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t            state;
    state_t            enter_state;
    logic              enter;
    logic              sweeping;
    logic              writing;
    logic              exit_ok;
    logic              sweep_done;
    logic              alu_seen;
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  wr_expect;
    logic [ITER_W-1:0] iter_next;

    assign phase = state;

    always_comb begin
        sweeping    = (state == S_MATVEC) || (state == S_ALPHA) || (state == S_UPDATE) ||
                      (state == S_BETA) || (state == S_PUPDATE);
        writing     = (state == S_MATVEC) || (state == S_UPDATE) || (state == S_PUPDATE);
        wr_expect   = writing ? WR_FULL : '0;
        exit_ok     = sweep_done && alu_seen && (wr_cnt == wr_expect);
        iter_next   = iter_count + ITER_W'(1);
        enter       = 1'b0;
        enter_state = S_IDLE;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    enter       = 1'b1;
                    enter_state = S_MATVEC;
                end
            end
            S_CHECK: begin
                if (!converged && (iter_next != ITER_LAST)) begin
                    enter       = 1'b1;
                    enter_state = S_MATVEC;
                end
            end
            default: begin
                if (exit_ok) begin
                    enter = 1'b1;
                    case (state)
                        S_MATVEC: enter_state = S_ALPHA;
                        S_ALPHA:  enter_state = S_UPDATE;
                        S_UPDATE: enter_state = S_BETA;
                        S_BETA:   enter_state = S_PUPDATE;
                        default:  enter_state = S_CHECK;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            a_rd_en     <= 1'b0;
            a_rd_addr   <= '0;
            vec_rd_en   <= 1'b0;
            vec_rd_addr <= '0;
            vec_wr_addr <= '0;
            wr_en_ap    <= 1'b0;
            wr_en_x     <= 1'b0;
            wr_en_r     <= 1'b0;
            wr_en_p     <= 1'b0;
            iter_count  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            conv_flag   <= 1'b0;
            wr_overflow <= 1'b0;
            sweep_done  <= 1'b0;
            alu_seen    <= 1'b0;
            wr_cnt      <= '0;
        end else begin
            wr_en_ap <= 1'b0;
            wr_en_x  <= 1'b0;
            wr_en_r  <= 1'b0;
            wr_en_p  <= 1'b0;
            if (abort) begin
                state       <= S_IDLE;
                a_rd_en     <= 1'b0;
                a_rd_addr   <= '0;
                vec_rd_en   <= 1'b0;
                vec_rd_addr <= '0;
                vec_wr_addr <= '0;
                busy        <= 1'b0;
                done        <= 1'b0;
                sweep_done  <= 1'b0;
                alu_seen    <= 1'b0;
                wr_cnt      <= '0;
            end else begin
                // vec_rd_en is high in every sweep, so it also marks an unfinished sweep
                if (sweeping && vec_rd_en && !stall) begin
                    if ((state == S_MATVEC) ? (a_rd_addr == A_LAST) : (vec_rd_addr == V_LAST)) begin
                        a_rd_en     <= 1'b0;
                        vec_rd_en   <= 1'b0;
                        a_rd_addr   <= '0;
                        vec_rd_addr <= '0;
                        sweep_done  <= 1'b1;
                    end else begin
                        if (state == S_MATVEC) a_rd_addr <= a_rd_addr + ADDR_W'(1);
                        vec_rd_addr <= (vec_rd_addr == V_LAST) ? '0 : vec_rd_addr + ADDR_W'(1);
                    end
                end
                if (sweeping && alu_done) alu_seen <= 1'b1;
                if (result_valid && (sweeping || (state == S_CHECK))) begin
                    if (writing && (wr_cnt != wr_expect)) begin
                        wr_en_ap    <= (state == S_MATVEC);
                        wr_en_x     <= (state == S_UPDATE);
                        wr_en_r     <= (state == S_UPDATE);
                        wr_en_p     <= (state == S_PUPDATE);
                        vec_wr_addr <= ADDR_W'(wr_cnt);
                        wr_cnt      <= wr_cnt + CNT_W'(1);
                    end else begin
                        wr_overflow <= 1'b1;
                    end
                end
                if (state == S_CHECK) begin
                    iter_count <= iter_next;
                    if (converged || (iter_next == ITER_LAST)) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        conv_flag <= converged;
                    end
                end
                if (((state == S_IDLE) || (state == S_DONE)) && start) begin
                    iter_count  <= '0;
                    conv_flag   <= 1'b0;
                    wr_overflow <= 1'b0;
                end
                // phase entry: the first read goes out in the same cycle the new phase is shown
                if (enter) begin
                    state       <= enter_state;
                    a_rd_en     <= (enter_state == S_MATVEC);
                    vec_rd_en   <= (enter_state != S_CHECK);
                    a_rd_addr   <= '0;
                    vec_rd_addr <= '0;
                    vec_wr_addr <= '0;
                    sweep_done  <= 1'b0;
                    alu_seen    <= 1'b0;
                    wr_cnt      <= '0;
                    busy        <= 1'b1;
                    done        <= 1'b0;
                end
            end
        end
    end
endmodule
